// File: rtl/module_banco_de_registros_sb.sv
// Register file with two write ports, optional write-to-read bypass, and an
// issue/writeback scoreboard that drives per-read-port hazard flags.
module module_banco_de_registros_sb #(
   parameter int N      = 32,
   parameter int W      = 32,
   parameter int NR     = 2,
   parameter int BYPASS = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NR*$clog2(N)-1:0]   addr_rs,
   output logic [NR*W-1:0]           rs,
   output logic [NR-1:0]             rs_hazard,
   input  logic                      we0,
   input  logic [$clog2(N)-1:0]      addr_rd0,
   input  logic [W-1:0]              data_in0,
   input  logic                      we1,
   input  logic [$clog2(N)-1:0]      addr_rd1,
   input  logic [W-1:0]              data_in1,
   input  logic                      issue_valid,
   input  logic [$clog2(N)-1:0]      issue_rd,
   output logic [N-1:0]              busy
);

   localparam int AW = $clog2(N);

   logic [W-1:0] regs_q [N];
   logic [N-1:0] busy_q;
   logic [N-1:0] busy_d;

   // Issue is evaluated first so that a same-cycle writeback cannot clear a
   // destination that was just re-issued.
   always_comb begin
      busy_d = busy_q;
      for (int k = 1; k < N; k++) begin
         if (issue_valid && (issue_rd == AW'(k))) begin
            busy_d[k] = 1'b1;
         end else if ((we0 && (addr_rd0 == AW'(k))) ||
                      (we1 && (addr_rd1 == AW'(k)))) begin
            busy_d[k] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Port 1 is assigned last so it wins a same-address dual write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            regs_q[k] <= '0;
         end
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
         if (we0 && (addr_rd0 != '0)) begin
            regs_q[addr_rd0] <= data_in0;
         end
         if (we1 && (addr_rd1 != '0)) begin
            regs_q[addr_rd1] <= data_in1;
         end
      end
   end

   assign busy = busy_q;

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit0;
      logic          hit1;

      assign ra   = addr_rs[i*AW +: AW];
      assign hit1 = (BYPASS != 0) && we1 && (addr_rd1 == ra) && (ra != '0);
      assign hit0 = (BYPASS != 0) && we0 && (addr_rd0 == ra) && (ra != '0);

      // regs_q[0] is never written, so address 0 reads zero without a mux term.
      assign rs[i*W +: W]  = hit1 ? data_in1 : (hit0 ? data_in0 : regs_q[ra]);
      assign rs_hazard[i]  = busy_q[ra] && !(hit0 || hit1);
   end

endmodule

// File: tb/tb_module_banco_de_registros_sb.sv
// Bench for the scoreboarded register file: three instances (bypass, no bypass,
// four read ports) share write/issue stimulus and are checked against one model.
module tb_module_banco_de_registros_sb;

   logic        clk;
   logic        rst;
   logic [9:0]  addr_rs_ab;
   logic [19:0] addr_rs_c;
   logic        we0, we1, issue_valid;
   logic [4:0]  addr_rd0, addr_rd1, issue_rd;
   logic [31:0] data_in0, data_in1;

   logic [63:0]  rs_a, rs_b;
   logic [127:0] rs_c;
   logic [1:0]   rs_hz_a, rs_hz_b;
   logic [3:0]   rs_hz_c;
   logic [31:0]  busy_a, busy_b, busy_c;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 0;

   logic [31:0] mreg [32];
   bit          mbusy [32];

   module_banco_de_registros_sb #(.N(32), .W(32), .NR(2), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .addr_rs(addr_rs_ab), .rs(rs_a), .rs_hazard(rs_hz_a),
      .we0(we0), .addr_rd0(addr_rd0), .data_in0(data_in0),
      .we1(we1), .addr_rd1(addr_rd1), .data_in1(data_in1),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy_a));

   module_banco_de_registros_sb #(.N(32), .W(32), .NR(2), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .addr_rs(addr_rs_ab), .rs(rs_b), .rs_hazard(rs_hz_b),
      .we0(we0), .addr_rd0(addr_rd0), .data_in0(data_in0),
      .we1(we1), .addr_rd1(addr_rd1), .data_in1(data_in1),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy_b));

   module_banco_de_registros_sb #(.N(32), .W(32), .NR(4), .BYPASS(1)) u_c (
      .clk(clk), .rst(rst), .addr_rs(addr_rs_c), .rs(rs_c), .rs_hazard(rs_hz_c),
      .we0(we0), .addr_rd0(addr_rd0), .data_in0(data_in0),
      .we1(we1), .addr_rd1(addr_rd1), .data_in1(data_in1),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy_c));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Model: writes applied in port order (port 1 last wins), then issue sets busy.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 32; k++) begin
            mreg[k]  = '0;
            mbusy[k] = 0;
         end
      end else begin
         if (we0 && addr_rd0 != 0) mreg[addr_rd0] = data_in0;
         if (we1 && addr_rd1 != 0) mreg[addr_rd1] = data_in1;
         if (we0) mbusy[addr_rd0] = 0;
         if (we1) mbusy[addr_rd1] = 0;
         if (issue_valid) mbusy[issue_rd] = 1;
         mbusy[0] = 0;
      end
   end

   function automatic bit fwd(input int a, input bit byp);
      return byp && a != 0 && ((we1 && int'(addr_rd1) == a) || (we0 && int'(addr_rd0) == a));
   endfunction

   function automatic logic [31:0] exp_rd(input int a, input bit byp);
      if (a == 0) return '0;
      if (byp && we1 && int'(addr_rd1) == a) return data_in1;
      if (byp && we0 && int'(addr_rd0) == a) return data_in0;
      return mreg[a];
   endfunction

   function automatic bit exp_hz(input int a, input bit byp);
      return a != 0 && mbusy[a] && !fwd(a, byp);
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] b;
      for (int k = 0; k < 32; k++) b[k] = mbusy[k];
      return b;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, idx, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk("A.rs", i, rs_a[i*32 +: 32], exp_rd(int'(addr_rs_ab[i*5 +: 5]), 1));
            chk("A.hz", i, rs_hz_a[i], exp_hz(int'(addr_rs_ab[i*5 +: 5]), 1));
            chk("B.rs", i, rs_b[i*32 +: 32], exp_rd(int'(addr_rs_ab[i*5 +: 5]), 0));
            chk("B.hz", i, rs_hz_b[i], exp_hz(int'(addr_rs_ab[i*5 +: 5]), 0));
         end
         for (int i = 0; i < 4; i++) begin
            chk("C.rs", i, rs_c[i*32 +: 32], exp_rd(int'(addr_rs_c[i*5 +: 5]), 1));
            chk("C.hz", i, rs_hz_c[i], exp_hz(int'(addr_rs_c[i*5 +: 5]), 1));
         end
         chk("A.busy", 0, busy_a, exp_busy());
         chk("B.busy", 0, busy_b, exp_busy());
         chk("C.busy", 0, busy_c, exp_busy());
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit e0, input int a0, input logic [31:0] d0,
                     input bit e1, input int a1, input logic [31:0] d1,
                     input bit iv, input int ird);
      we0 = e0; addr_rd0 = 5'(a0); data_in0 = d0;
      we1 = e1; addr_rd1 = 5'(a1); data_in1 = d1;
      issue_valid = iv; issue_rd = 5'(ird);
   endtask

   task automatic rd(input int p0, input int p1, input int p2, input int p3);
      addr_rs_ab = {5'(p1), 5'(p0)};
      addr_rs_c  = {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
   endtask

   initial begin
      rst = 1;
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      rd(0, 0, 0, 0);
      #2 rst = 0;
      // Write and issue presented during reset must be discarded.
      wr(1, 6, 32'h66, 0, 0, 0, 1, 6);
      #1 chk_en = 1;
      chk("rst.busy", 0, busy_a, 0);
      chk("rst.rs", 0, rs_a, 0);
      repeat (2) cyc();
      rst = 1;
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      rd(6, 0, 0, 0);

      cyc();
      wr(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5);
      #1 chk("x6.dropped", 0, rs_a[31:0], 0);
      chk("x6.busy", 0, busy_a, 0);

      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      rd(5, 0, 0, 0);
      #1 chk("x5.read", 0, rs_a[31:0], 32'hDEADBEEF);
      chk("x5.busy", 0, busy_a, 32'h20);
      chk("x5.hz", 0, rs_hz_a, 2'b01);
      #1 rst = 0;
      #1 chk("async.rs", 0, rs_a, 0);
      chk("async.busy", 0, busy_a, 0);
      chk("async.hz", 0, rs_hz_a, 0);
      chk("async.busyB", 0, busy_b, 0);
      rst = 1;

      cyc();
      wr(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0);
      rd(0, 0, 0, 0);
      #1 chk("x0.rs", 0, rs_a, 0);
      chk("x0.hz", 0, rs_hz_a, 0);
      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("x0.busy", 0, busy_a, 0);
      chk("x0.rs2", 0, rs_a, 0);

      cyc();
      wr(1, 7, 32'h11, 1, 7, 32'h22, 0, 0);
      rd(7, 7, 0, 0);
      #1 chk("dual.byp", 0, rs_a, 64'h00000022_00000022);
      chk("dual.nobyp", 0, rs_b[31:0], 0);
      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("dual.A", 0, rs_a[31:0], 32'h22);
      chk("dual.B", 0, rs_b[31:0], 32'h22);

      cyc();
      wr(1, 3, 32'h5, 0, 0, 0, 0, 0);
      cyc();
      wr(1, 3, 32'hA, 0, 0, 0, 0, 0);
      rd(3, 0, 0, 0);
      #1 chk("byp.A", 0, rs_a[31:0], 32'hA);
      chk("byp.B", 0, rs_b[31:0], 32'h5);
      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("byp.Bnext", 0, rs_b[31:0], 32'hA);

      cyc();
      wr(0, 0, 0, 0, 0, 0, 1, 9);
      rd(9, 0, 0, 0);
      #1 chk("sb.pre", 0, rs_hz_a, 0);
      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("sb.busy", 0, busy_a, 32'h200);
      chk("sb.hz", 0, rs_hz_a, 2'b01);
      cyc();
      wr(0, 0, 0, 1, 9, 32'h99, 0, 0);
      #1 chk("sb.fwdA", 0, rs_hz_a, 0);
      chk("sb.fwdB", 0, rs_hz_b, 2'b01);
      chk("sb.data", 0, rs_a[31:0], 32'h99);
      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("sb.clr", 0, busy_a, 0);
      chk("sb.hzclr", 0, rs_hz_a, 0);

      cyc();
      wr(0, 0, 0, 0, 0, 0, 1, 4);
      rd(4, 0, 0, 0);
      cyc();
      wr(1, 4, 32'h44, 0, 0, 0, 1, 4);
      #1 chk("col.hzA", 0, rs_hz_a, 0);
      chk("col.hzB", 0, rs_hz_b, 2'b01);
      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      rd(4, 9, 7, 3);
      #1 chk("col.busy", 0, busy_a, 32'h10);
      chk("col.data", 0, rs_a[31:0], 32'h44);
      chk("nr4.rs", 0, rs_c, {32'hA, 32'h22, 32'h99, 32'h44});
      chk("nr4.hz", 0, rs_hz_c, 4'b0001);

      cyc();
      wr(0, 0, 0, 1, 4, 32'h55, 1, 7);
      #1 chk("nr4.fwd", 0, rs_c[31:0], 32'h55);
      chk("nr4.hzfwd", 0, rs_hz_c, 4'b0000);
      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("nr4.busy", 0, busy_c, 32'h80);
      chk("nr4.hz7", 0, rs_hz_c, 4'b0100);

      cyc();
      wr(0, 0, 0, 1, 12, 32'hC, 0, 0);
      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      rd(12, 7, 0, 4);
      #1 chk("nb.busy", 0, busy_c, 32'h80);
      chk("nb.data", 0, rs_c[31:0], 32'hC);

      for (int j = 0; j < 24; j++) begin
         cyc();
         wr(j % 2 == 0, (j * 7) % 32, 32'h01010101 * j,
            j % 3 == 0, (j * 5) % 32, ~(32'h00000101 * j),
            j % 4 == 1, (j * 3) % 32);
         rd(j % 32, (j + 9) % 32, (j * 7) % 32, (j * 5) % 32);
      end

      cyc();
      wr(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      #5;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
